icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache sitting between one core's fetch stage and the instruction port of the memory controller. Hits return in the same cycle. Misses run a single-word fill through the controller's iREN/iwait handshake, then retry. One instance per core; the controller arbitrates between instances.

---
 rtl/icache_direct.sv | 117 +++++++++++
 tb/tb_icache_direct.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with one-word lines.
// Hits are answered combinationally. A miss starts a single-word fill through
// the controller's iREN/iwait handshake, and the fetch is then retried.
// Optional feature macro: ICACHE_STATS_EN adds saturating hit and miss counters.
// Without the macro, hit_count and miss_count are tied to 0.
module icache_direct #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  logic [SETS-1:0] valid;
  logic [TW-1:0]   tags [SETS];
  logic [31:0]     data [SETS];
  logic [29:0]     fill_addr;

  logic [TW-1:0]   req_tag;
  logic [IW-1:0]   req_idx;
  logic [TW-1:0]   fill_tag;
  logic [IW-1:0]   fill_idx;
  logic            lookup_hit;
  logic            miss_start;
  logic            fill_done;
  logic            unused_addr_lsb;

  assign req_tag  = imemaddr[31:IW+2];
  assign req_idx  = imemaddr[IW+1:2];
  assign fill_tag = fill_addr[29:IW];
  assign fill_idx = fill_addr[IW-1:0];

  // Byte offset within the word carries no information for a word fetch.
  assign unused_addr_lsb = ^imemaddr[1:0];

  assign lookup_hit = imemREN && valid[req_idx] && (tags[req_idx] == req_tag);
  assign miss_start = (state == IDLE) && imemREN && !lookup_hit;
  assign fill_done  = (state == FILL) && !iwait;

  // Fetch-side responses: only IDLE can answer; FILL never reports a hit.
  assign ihit     = (state == IDLE) && lookup_hit;
  assign imemload = ihit ? data[req_idx] : 32'h0;

  // Fill request follows the state register directly, so it cannot glitch.
  assign iREN  = (state == FILL);
  assign iaddr = iREN ? {fill_addr, 2'b00} : 32'h0;

  // Controller: latch the missing word address and hold it for the whole fill.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      fill_addr <= '0;
    end else begin
      case (state)
        IDLE: if (miss_start) begin
          state     <= FILL;
          fill_addr <= imemaddr[31:2];
        end
        FILL: if (!iwait) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: flush wins over a fill landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST)          valid <= '0;
    else if (iflush)    valid <= '0;
    else if (fill_done) valid[fill_idx] <= 1'b1;
  end

  // Tag/data store: written on fill completion; a discarded fill leaves the line invalid.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Saturating event counters; flush leaves them alone.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (ihit && (hit_q != 32'hFFFF_FFFF))        hit_q  <= hit_q + 32'd1;
      if (miss_start && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a word-address reference model of the cache checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_icache_direct;
  localparam int SETS = 16;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_direct #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each line remembers the full word address it holds.
  bit          m_fill = 1'b0;
  logic [29:0] m_faddr = '0;
  bit          m_valid [SETS];
  logic [29:0] m_line [SETS];
  logic [31:0] m_data [SETS];
  logic [31:0] m_hits = '0;
  logic [31:0] m_misses = '0;

  function automatic int widx(input logic [29:0] w);
    return int'(w % SETS);
  endfunction

  function automatic bit model_hit();
    logic [29:0] w;
    w = imemaddr[31:2];
    return !m_fill && imemREN && m_valid[widx(w)] && (m_line[widx(w)] == w);
  endfunction

  always @(posedge CLK) begin
    bit h;
    h = model_hit();
    if (!nRST) begin
      m_fill = 1'b0;
      m_faddr = '0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_hits = '0;
      m_misses = '0;
    end else begin
      if (h && m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
      if (!m_fill) begin
        if (imemREN && !h) begin
          m_fill = 1'b1;
          m_faddr = imemaddr[31:2];
          if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
        end
      end else if (!iwait) begin
        if (!iflush) begin
          m_valid[widx(m_faddr)] = 1'b1;
          m_line[widx(m_faddr)]  = m_faddr;
          m_data[widx(m_faddr)]  = iload;
        end
        m_fill = 1'b0;
      end
      if (iflush) foreach (m_valid[i]) m_valid[i] = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      bit h;
      h = model_hit();
      check("ihit", 32'(ihit), 32'(h));
      check("imemload", imemload, h ? m_data[widx(imemaddr[31:2])] : 32'h0);
      check("iREN", 32'(iREN), 32'(m_fill));
      check("iaddr", iaddr, m_fill ? {m_faddr, 2'b00} : 32'h0);
      check("hit_count", hit_count, STATS ? m_hits : 32'h0);
      check("miss_count", miss_count, STATS ? m_misses : 32'h0);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    @(negedge CLK);
    #1;
  endtask

  // Request addr, take the miss, wait w cycles, then deliver d.
  task automatic fill_at(input logic [31:0] addr, input int w, input logic [31:0] d);
    imemREN = 1'b1;
    imemaddr = addr;
    iwait = 1'b1;
    cyc();
    for (int k = 0; k < w; k++) cyc();
    iwait = 1'b0;
    iload = d;
    cyc();
    iwait = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0;
    iwait = 1'b1; iload = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    settle();
    check("reset_ihit", 32'(ihit), 32'h0);
    check("reset_iREN", 32'(iREN), 32'h0);
    check("reset_iaddr", iaddr, 32'h0);
    check("reset_imemload", imemload, 32'h0);
    check("reset_hit_count", hit_count, 32'h0);
    nRST = 1'b1;
    cyc();

    // Cold miss with three wait cycles.
    imemREN = 1'b1; imemaddr = 32'h40; iwait = 1'b1;
    settle();
    check("cold_detect_ihit", 32'(ihit), 32'h0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      iwait = (k < 3);
      iload = (k == 3) ? 32'h2001_0005 : $urandom;
      settle();
      check("cold_iREN", 32'(iREN), 32'h1);
      check("cold_iaddr", iaddr, 32'h40);
      cyc();
    end
    iwait = 1'b1;
    settle();
    check("cold_hit", 32'(ihit), 32'h1);
    check("cold_data", imemload, 32'h2001_0005);
    cyc();

    // Conflict on index 0 between 0x40 and 0x440.
    fill_at(32'h440, 0, 32'hAAAA_0440);
    settle();
    check("conflict_fill_hit", imemload, 32'hAAAA_0440);
    cyc();
    imemaddr = 32'h40;
    settle();
    check("conflict_evict", 32'(ihit), 32'h0);
    fill_at(32'h40, 1, 32'h2001_0005);
    settle();
    check("refill_hit", 32'(ihit), 32'h1);
    if (STATS) check("miss_count_3", miss_count, 32'd3);
    cyc();

    // Address change while the fill is in flight.
    imemaddr = 32'h80;
    cyc();
    imemaddr = 32'h100;
    settle();
    check("addr_hold_iaddr", iaddr, 32'h80);
    cyc();
    iwait = 1'b0; iload = 32'h8080_8080;
    settle();
    check("addr_hold_iaddr2", iaddr, 32'h80);
    cyc();
    iwait = 1'b1; imemaddr = 32'h80;
    settle();
    check("addr_hold_line80", imemload, 32'h8080_8080);
    cyc();
    imemaddr = 32'h100;
    settle();
    check("addr_hold_100_miss", 32'(ihit), 32'h0);
    cyc();
    iwait = 1'b0;
    cyc();
    iwait = 1'b1; imemREN = 1'b0;

    // Flush, then a flush colliding with fill completion.
    iflush = 1'b1;
    cyc();
    iflush = 1'b0; imemREN = 1'b1; imemaddr = 32'h80;
    settle();
    check("flush_clears", 32'(ihit), 32'h0);
    cyc();
    iwait = 1'b0; iflush = 1'b1; iload = 32'h1234_5678;
    cyc();
    iflush = 1'b0; iwait = 1'b1;
    settle();
    check("flush_collision_miss", 32'(ihit), 32'h0);
    cyc();
    settle();
    check("flush_collision_refill", 32'(iREN), 32'h1);
    iwait = 1'b0;
    cyc();
    iwait = 1'b1;

    // Reset in the middle of a fill.
    fill_at(32'h40, 0, 32'h4040_4040);
    settle();
    check("pre_reset_hit", 32'(ihit), 32'h1);
    cyc();
    imemaddr = 32'h200;
    cyc();
    nRST = 1'b0;
    cyc();
    nRST = 1'b1; imemaddr = 32'h40;
    settle();
    check("rst_fill_iREN", 32'(iREN), 32'h0);
    check("rst_fill_ihit", 32'(ihit), 32'h0);
    check("rst_fill_hits", hit_count, 32'h0);
    check("rst_fill_misses", miss_count, 32'h0);
    cyc();

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 4000; n++) begin
      imemREN  = ($urandom_range(0, 3) != 0);
      imemaddr = (32'($urandom_range(0, 3)) << (2 + $clog2(SETS))) |
                 (32'($urandom_range(0, SETS - 1)) << 2) |
                 32'($urandom_range(0, 3));
      iwait    = $urandom_range(0, 1) == 1;
      iflush   = ($urandom_range(0, 24) == 0);
      nRST     = ($urandom_range(0, 199) != 0);
      iload    = $urandom;
      cyc();
    end

    nRST = 1'b1; imemREN = 1'b0; iflush = 1'b0;
    cyc();
    settle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
